branch_resolve_unit: RTL and testbench



---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_pred_fifo.sv | 58 +++++
 rtl/branch_resolve_unit.sv | 89 ++++++++
 tb/tb_branch_resolve_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// bp_pkg : shared types and defaults for the branch resolve unit
// Rev 1.0
// ============================================================================
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_XLEN  = 32;
  localparam int BP_CNTW  = 16;

  localparam logic BP_NT = 1'b0;
  localparam logic BP_T  = 1'b1;

  typedef struct packed {
    logic               taken;
    logic [BP_XLEN-1:0] target;
  } bp_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_pred_fifo.sv
`default_nettype none
// ============================================================================
// bp_pred_fifo : in-flight prediction queue, oldest entry at the head
// Rev 1.0
// ============================================================================
module bp_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && w_push) r_mem[r_wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// branch_resolve_unit : checks resolved branches against queued predictions,
// issues flush/redirect and predictor training, keeps statistics.  Rev 1.0
// ============================================================================
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int XLEN  = BP_XLEN,
  parameter int CNTW  = BP_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [CNTW-1:0] n_branch,
  output logic [CNTW-1:0] n_mispred,
  output logic            underflow
);

  localparam int EW = XLEN + 1;

  logic [EW-1:0]   w_head;
  logic            w_head_taken;
  logic [XLEN-1:0] w_head_target;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_mispred;

  assign w_head_taken  = w_head[XLEN];
  assign w_head_target = w_head[XLEN-1:0];

  // The queue is already empty during the flush cycle, so ready is forced high
  // while the push itself is discarded.
  assign pred_ready = flush | ~w_full;
  assign w_push     = pred_valid & pred_ready & ~flush;
  assign w_pop      = res_valid & ~w_empty;
  assign w_mispred  = w_pop & ((w_head_taken != res_taken) |
                               (w_head_target != res_target));

  bp_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push & ~w_mispred),
    .pop   (w_pop),
    .clear (w_mispred),
    .wdata ({pred_taken, pred_target}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_taken   <= BP_NT;
      n_branch    <= '0;
      n_mispred   <= '0;
      underflow   <= 1'b0;
    end else begin
      flush     <= w_mispred;
      upd_valid <= w_pop;
      upd_taken <= w_pop ? res_taken : BP_NT;
      if (w_mispred) redirect_pc <= res_target;
      if (w_pop && (n_branch != '1)) n_branch <= n_branch + 1'b1;
      if (w_mispred && (n_mispred != '1)) n_mispred <= n_mispred + 1'b1;
      if (res_valid && w_empty) underflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_unit : directed stimulus with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_branch_resolve_unit;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            pred_valid = 1'b0;
  logic            pred_taken = 1'b0;
  logic [XLEN-1:0] pred_target = '0;
  logic            pred_ready;
  logic            res_valid = 1'b0;
  logic            res_taken = 1'b0;
  logic [XLEN-1:0] res_target = '0;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic            upd_taken;
  logic [CNTW-1:0] n_branch;
  logic [CNTW-1:0] n_mispred;
  logic            underflow;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk (clk), .reset (reset),
    .pred_valid (pred_valid), .pred_taken (pred_taken), .pred_target (pred_target),
    .pred_ready (pred_ready),
    .res_valid (res_valid), .res_taken (res_taken), .res_target (res_target),
    .flush (flush), .redirect_pc (redirect_pc),
    .upd_valid (upd_valid), .upd_taken (upd_taken),
    .n_branch (n_branch), .n_mispred (n_mispred), .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of predictions plus expected output values.
  bp_entry_t   mq[$];
  logic        live = 1'b0;
  logic        m_flush, m_uv, m_ut, m_uf;
  logic [31:0] m_redir;
  int          m_nb, m_nm;

  always @(posedge clk) begin
    bp_entry_t e;
    logic ready, pop, mis;
    if (reset) begin
      mq.delete();
      m_flush = 0; m_uv = 0; m_ut = 0; m_uf = 0; m_redir = 0; m_nb = 0; m_nm = 0;
      live = 1'b1;
    end else if (live) begin
      ready = m_flush || (mq.size() < DEPTH);
      pop = 0; mis = 0;
      if (res_valid) begin
        if (mq.size() == 0) m_uf = 1;
        else begin
          pop = 1;
          e = mq.pop_front();
          mis = (e.taken != res_taken) || (e.target != res_target);
        end
      end
      if (mis) mq.delete();
      else if (pred_valid && ready && !m_flush) begin
        e.taken = pred_taken; e.target = pred_target;
        mq.push_back(e);
      end
      m_flush = mis;
      if (mis) m_redir = res_target;
      m_uv = pop;
      if (pop) m_ut = res_taken;
      if (pop && m_nb < CMAX) m_nb++;
      if (mis && m_nm < CMAX) m_nm++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("pred_ready", pred_ready, m_flush || (mq.size() < DEPTH));
      check("flush", flush, m_flush);
      check("redirect_pc", redirect_pc, m_redir);
      check("upd_valid", upd_valid, m_uv);
      if (m_uv) check("upd_taken", upd_taken, m_ut);
      check("n_branch", n_branch, m_nb);
      check("n_mispred", n_mispred, m_nm);
      check("underflow", underflow, m_uf);
    end
  end

  task automatic drive(input logic pv, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    @(negedge clk);
    pred_valid = pv; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; pred_valid = 0; res_valid = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst flush", flush, 0);
    check("rst redirect", redirect_pc, 0);
    check("rst upd_valid", upd_valid, 0);
    check("rst upd_taken", upd_taken, 0);
    check("rst n_branch", n_branch, 0);
    check("rst n_mispred", n_mispred, 0);
    check("rst underflow", underflow, 0);
    check("rst pred_ready", pred_ready, 1);
    reset = 0;

    // Correct prediction
    drive(1, BP_T, 32'h40, 0, 0, 0);
    drive(0, 0, 0, 1, BP_T, 32'h40);
    idle();
    check("ok upd_valid", upd_valid, 1);
    check("ok upd_taken", upd_taken, 1);
    check("ok flush", flush, 0);
    check("ok n_branch", n_branch, 1);
    check("ok n_mispred", n_mispred, 0);

    // Mispredict: direction and target wrong
    do_reset();
    drive(1, BP_NT, 32'h104, 0, 0, 0);
    drive(0, 0, 0, 1, BP_T, 32'h200);
    idle();
    check("mp flush", flush, 1);
    check("mp redirect", redirect_pc, 32'h200);
    check("mp upd_taken", upd_taken, 1);
    check("mp n_mispred", n_mispred, 1);
    check("mp pred_ready", pred_ready, 1);
    idle();
    check("mp flush one cycle", flush, 0);
    check("mp redirect held", redirect_pc, 32'h200);

    // Fill to DEPTH, drop a 5th push, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, i[0], 32'h1000 + 4 * i, 0, 0, 0);
    idle();
    check("full pred_ready", pred_ready, 0);
    drive(1, 1, 32'h2000, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 1, i[0], 32'h1000 + 4 * i);
    idle();
    check("drain n_branch", n_branch, 4);
    check("drain n_mispred", n_mispred, 0);
    check("drain pred_ready", pred_ready, 1);
    drive(0, 0, 0, 1, 1, 32'h2000);
    idle();
    check("drain empty underflow", underflow, 1);
    check("drain empty no update", upd_valid, 0);

    // Mispredict with younger entries and a same-cycle push
    do_reset();
    drive(1, 1, 32'h300, 0, 0, 0);
    drive(1, 0, 32'h304, 0, 0, 0);
    drive(1, 1, 32'h308, 0, 0, 0);
    drive(1, 1, 32'h400, 1, 0, 32'h300);
    idle();
    check("wp flush", flush, 1);
    check("wp redirect", redirect_pc, 32'h300);
    drive(0, 0, 0, 1, 1, 32'h400);
    idle();
    check("wp underflow", underflow, 1);
    check("wp no update", upd_valid, 0);
    check("wp n_branch", n_branch, 1);

    // Counter saturation
    do_reset();
    drive(1, 1, 32'h5000, 0, 0, 0);
    for (int k = 1; k < 18; k++)
      drive(1, 1, 32'h5000 + 4 * k, 1, 1, 32'h5000 + 4 * (k - 1));
    drive(0, 0, 0, 1, 1, 32'h5000 + 4 * 17);
    idle();
    check("sat n_branch", n_branch, 15);
    check("sat no mispred", n_mispred, 0);
    for (int k = 0; k < 17; k++) begin
      drive(1, 0, 32'h6000, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 32'h7000);
      idle();
    end
    check("sat n_mispred", n_mispred, 15);
    check("sat n_branch held", n_branch, 15);

    // Reset mid-operation with a resolve pending
    do_reset();
    drive(1, 1, 32'h800, 0, 0, 0);
    drive(1, 1, 32'h804, 0, 0, 0);
    drive(1, 1, 32'h808, 1, 0, 32'h999);
    reset = 1;
    @(negedge clk);
    check("mr flush", flush, 0);
    check("mr upd_valid", upd_valid, 0);
    check("mr n_branch", n_branch, 0);
    check("mr n_mispred", n_mispred, 0);
    check("mr redirect", redirect_pc, 0);
    check("mr pred_ready", pred_ready, 1);
    reset = 0; pred_valid = 0; res_valid = 0;
    drive(0, 0, 0, 1, 1, 32'h800);
    idle();
    check("mr entries discarded", underflow, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
